// File: rtl/tri_scan_if.sv
// Point/result channel between the triangle scanner and the point-test block.
interface tri_scan_if #(
   parameter int CW = 9
);
   logic [CW-1:0] px;
   logic [CW-1:0] py;
   logic          p_valid;
   logic          p_ready;
   logic          r_valid;
   logic          r_in;

   modport master (
      output px, py, p_valid,
      input  p_ready, r_valid, r_in
   );

   modport slave (
      input  px, py, p_valid,
      output p_ready, r_valid, r_in
   );
endinterface

// File: rtl/tri_scan.sv
// Bounding-box raster scanner for the point-in-triangle test: issues one point at a
// time, collects the inside result, and counts issued and inside points.
module tri_scan #(
   parameter int CW = 9,
   parameter int NW = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] ax,
   input  logic [CW-1:0] bx,
   input  logic [CW-1:0] cx,
   input  logic [CW-1:0] ay,
   input  logic [CW-1:0] by,
   input  logic [CW-1:0] cy,
   tri_scan_if.master    pif,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] inside_cnt,
   output logic [NW-1:0] point_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BBOX,
      S_ISSUE,
      S_WAIT,
      S_STEP,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0] ax_q, bx_q, cx_q, ay_q, by_q, cy_q;
   logic [CW-1:0] xmin_q, xmax_q, ymax_q;
   logic [CW-1:0] px_q, py_q;

   function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      busy        = 1'b1;
      done        = 1'b0;
      pif.p_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_BBOX;
         end
         S_BBOX:  state_d = S_ISSUE;
         S_ISSUE: begin
            pif.p_valid = 1'b1;
            if (pif.p_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (pif.r_valid) state_d = S_STEP;
         end
         S_STEP: begin
            // Termination is decided on the current point, so px/py never wrap at the top edge
            if ((px_q < xmax_q) || (py_q < ymax_q)) state_d = S_ISSUE;
            else                                    state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ax_q       <= '0;
         bx_q       <= '0;
         cx_q       <= '0;
         ay_q       <= '0;
         by_q       <= '0;
         cy_q       <= '0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymax_q     <= '0;
         px_q       <= '0;
         py_q       <= '0;
         inside_cnt <= '0;
         point_cnt  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ax_q <= ax;
                  bx_q <= bx;
                  cx_q <= cx;
                  ay_q <= ay;
                  by_q <= by;
                  cy_q <= cy;
               end
            end
            S_BBOX: begin
               xmin_q     <= min3(ax_q, bx_q, cx_q);
               xmax_q     <= max3(ax_q, bx_q, cx_q);
               ymax_q     <= max3(ay_q, by_q, cy_q);
               px_q       <= min3(ax_q, bx_q, cx_q);
               py_q       <= min3(ay_q, by_q, cy_q);
               inside_cnt <= '0;
               point_cnt  <= '0;
            end
            S_ISSUE: begin
               if (pif.p_ready) point_cnt <= point_cnt + 1'b1;
            end
            S_WAIT: begin
               if (pif.r_valid) inside_cnt <= inside_cnt + {{(NW-1){1'b0}}, pif.r_in};
            end
            S_STEP: begin
               if (px_q < xmax_q) begin
                  px_q <= px_q + 1'b1;
               end else if (py_q < ymax_q) begin
                  px_q <= xmin_q;
                  py_q <= py_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pif.px = px_q;
   assign pif.py = py_q;

endmodule
